// File: rtl/gray_conv_pkg.sv
// Shared constants and the mode encoding for the Gray/binary conversion blocks.
package gray_conv_pkg;

   localparam int GRAY_W_DEFAULT = 4;

   typedef enum logic {
      MODE_G2B = 1'b0,
      MODE_B2G = 1'b1
   } mode_e;

endpackage : gray_conv_pkg

// File: rtl/gray2bin_comb.sv
// Unregistered Gray-to-binary conversion: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray2bin_comb #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   logic acc;

   always_comb begin
      bin = '0;
      acc = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc    = acc ^ gray[i];
         bin[i] = acc;
      end
   end

endmodule : gray2bin_comb

// File: rtl/gray_to_binary_converter.sv
// Registered Gray<->binary converter, direction chosen per sample by mode,
// one-cycle latency with a valid flag. WIDTH is intended for 2..32.
module gray_to_binary_converter
   import gray_conv_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray,
   input  logic             mode,
   input  logic             in_valid,
   output logic [WIDTH-1:0] bin,
   output logic             out_valid
);

   logic [WIDTH-1:0] g2b_result;
   logic [WIDTH-1:0] b2g_result;
   logic [WIDTH-1:0] conv_result;
   mode_e            mode_sel;

   gray2bin_comb #(
      .WIDTH(WIDTH)
   ) u_gray2bin (
      .gray(gray),
      .bin (g2b_result)
   );

   assign b2g_result  = gray ^ (gray >> 1);
   assign mode_sel    = mode_e'(mode);
   assign conv_result = (mode_sel == MODE_B2G) ? b2g_result : g2b_result;

   // bin keeps its last result across idle cycles; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            bin <= conv_result;
         end
      end
   end

endmodule : gray_to_binary_converter

// File: tb/tb_gray_to_binary_converter.sv
// Directed self-checking bench for gray_to_binary_converter at WIDTH=4 and WIDTH=8.
module tb_gray_to_binary_converter;

   logic       clk;
   logic       rst_n;

   logic [3:0] gray4;
   logic       mode4;
   logic       iv4;
   logic [3:0] bin4;
   logic       ov4;

   logic [7:0] gray8;
   logic       mode8;
   logic       iv8;
   logic [7:0] bin8;
   logic       ov8;

   int         n_checks;
   int         n_errors;

   logic [3:0] g2b_in  [8];
   logic [3:0] g2b_exp [8];
   logic [3:0] b2g_in  [4];
   logic [3:0] b2g_exp [4];
   logic [3:0] tmp4;
   logic [7:0] tmp8;

   gray_to_binary_converter #(.WIDTH(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .gray     (gray4),
      .mode     (mode4),
      .in_valid (iv4),
      .bin      (bin4),
      .out_valid(ov4)
   );

   gray_to_binary_converter #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .gray     (gray8),
      .mode     (mode8),
      .in_valid (iv8),
      .bin      (bin8),
      .out_valid(ov8)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // drive on the falling edge, return 1 ns after the rising edge
   task automatic step4(input logic m, input logic [3:0] d, input logic v);
      @(negedge clk);
      mode4 = m;
      gray4 = d;
      iv4   = v;
      @(posedge clk);
      #1;
   endtask

   task automatic step8(input logic m, input logic [7:0] d, input logic v);
      @(negedge clk);
      mode8 = m;
      gray8 = d;
      iv8   = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      g2b_in  = '{4'b1101, 4'b1001, 4'b0111, 4'b1010, 4'b0101, 4'b0100, 4'b1000, 4'b1110};
      g2b_exp = '{4'b1001, 4'b1110, 4'b0101, 4'b1100, 4'b0110, 4'b0111, 4'b1111, 4'b1011};
      b2g_in  = '{4'b1001, 4'b1111, 4'b0000, 4'b0110};
      b2g_exp = '{4'b1101, 4'b1000, 4'b0000, 4'b0101};

      rst_n = 1'b0;
      gray4 = '0; mode4 = 1'b0; iv4 = 1'b0;
      gray8 = '0; mode8 = 1'b0; iv8 = 1'b0;
      #1;
      check("reset_bin4", 32'(bin4), 32'h0);
      check("reset_ov4",  32'(ov4),  32'h0);
      check("reset_bin8", 32'(bin8), 32'h0);
      check("reset_ov8",  32'(ov8),  32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Binary -> Gray vectors
      for (int i = 0; i < 4; i++) begin
         step4(1'b1, b2g_in[i], 1'b1);
         check($sformatf("b2g_%0d", i), 32'(bin4), 32'(b2g_exp[i]));
         check($sformatf("b2g_ov_%0d", i), 32'(ov4), 32'h1);
      end

      // Hold: one valid sample then three idle cycles with changing data
      step4(1'b0, 4'b1101, 1'b1);
      check("hold_first", 32'(bin4), 32'h9);
      check("hold_first_ov", 32'(ov4), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step4(1'b0, 4'($urandom_range(0, 15)), 1'b0);
         check($sformatf("hold_bin_%0d", i), 32'(bin4), 32'h9);
         check($sformatf("hold_ov_%0d", i), 32'(ov4), 32'h0);
      end

      // 4-bit round trip: B2G then G2B of the registered result, mode toggling
      for (int v = 0; v < 16; v++) begin
         step4(1'b1, 4'(v), 1'b1);
         tmp4 = bin4;
         step4(1'b0, tmp4, 1'b1);
         check($sformatf("rt4_%0d", v), 32'(bin4), 32'(v));
      end

      // Gray -> binary sequence, ends with bin=1011 and out_valid=1
      for (int i = 0; i < 8; i++) begin
         step4(1'b0, g2b_in[i], 1'b1);
         check($sformatf("g2b_%0d", i), 32'(bin4), 32'(g2b_exp[i]));
         check($sformatf("g2b_ov_%0d", i), 32'(ov4), 32'h1);
      end

      // Asynchronous reset mid-cycle, checked before the next clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_bin", 32'(bin4), 32'h0);
      check("async_rst_ov",  32'(ov4),  32'h0);

      // A sample presented while reset is held is discarded
      step4(1'b0, 4'b1101, 1'b1);
      check("rst_discard_bin", 32'(bin4), 32'h0);
      check("rst_discard_ov",  32'(ov4),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step4(1'b0, 4'b0111, 1'b1);
      check("post_rst_bin", 32'(bin4), 32'h5);
      check("post_rst_ov",  32'(ov4),  32'h1);
      step4(1'b0, 4'b0000, 1'b0);

      // WIDTH=8
      step8(1'b0, 8'b1000_0000, 1'b1);
      check("w8_g2b_msb", 32'(bin8), 32'hFF);
      check("w8_g2b_ov", 32'(ov8), 32'h1);
      for (int v = 0; v < 256; v++) begin
         step8(1'b1, 8'(v), 1'b1);
         tmp8 = bin8;
         step8(1'b0, tmp8, 1'b1);
         check($sformatf("rt8_%0d", v), 32'(bin8), 32'(v));
      end
      step8(1'b0, 8'h00, 1'b0);
      check("w8_idle_ov", 32'(ov8), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_gray_to_binary_converter
